// File: rtl/uarch_pkg.sv
// Shared micro-architecture constants and types for the return-address-stack path.
package uarch_pkg;

  localparam int unsigned CPU_ADDR_BITS = 32;
  localparam int unsigned RAS_DEPTH     = 16;
  localparam int unsigned FTQ_DEPTH     = 16;
  localparam int unsigned RAS_PW        = $clog2(RAS_DEPTH) + 1;
  localparam int unsigned FTQ_IW        = $clog2(FTQ_DEPTH);

  typedef logic [RAS_PW-1:0] ras_ptr_t;

  typedef enum logic [1:0] {
    RC_IDLE,
    RC_SWAP,
    RC_RECOVER,
    RC_REPAIR
  } ras_ctrl_state_e;

  // Redirecting instruction's own call/return effect, replayed after the restore.
  typedef struct packed {
    logic                     is_call;
    logic                     is_ret;
    logic [CPU_ADDR_BITS-1:0] ret_addr;
  } redir_req_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ras_ckpt_table.sv
// Per-FTQ-slot RAS pointer checkpoints with valid bits; accept writes, commit clears.
module ras_ckpt_table #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned PW    = 5,
  localparam int unsigned IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [PW-1:0] wr_ptr,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic [IW-1:0] rd_idx,
  output logic [PW-1:0] rd_ptr,
  output logic          rd_vld
);

  logic [PW-1:0]    ckpt_q [DEPTH];
  logic [PW-1:0]    ckpt_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  // Write applied after clear so an accept beats a same-slot commit.
  always_comb begin
    ckpt_d = ckpt_q;
    vld_d  = vld_q;
    if (clr_en) vld_d[clr_idx] = 1'b0;
    if (wr_en) begin
      ckpt_d[wr_idx] = wr_ptr;
      vld_d[wr_idx]  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ckpt_q <= '{default: '0};
      vld_q  <= '0;
    end else begin
      ckpt_q <= ckpt_d;
      vld_q  <= vld_d;
    end
  end

  assign rd_ptr = ckpt_q[rd_idx];
  assign rd_vld = vld_q[rd_idx];

endmodule

// File: rtl/ras_ctrl.sv
// RAS sequencing: turns fetch call/return hints into push/pop, restores the pointer
// on backend redirects and replays the redirecting instruction's own effect.
module ras_ctrl #(
  parameter  int unsigned RAS_DEPTH = uarch_pkg::RAS_DEPTH,
  parameter  int unsigned FTQ_DEPTH = uarch_pkg::FTQ_DEPTH,
  localparam int unsigned PW        = $clog2(RAS_DEPTH) + 1,
  localparam int unsigned IW        = $clog2(FTQ_DEPTH),
  localparam int unsigned AW        = uarch_pkg::CPU_ADDR_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fe_valid,
  input  logic          fe_is_call,
  input  logic          fe_is_ret,
  input  logic [AW-1:0] fe_ret_addr,
  input  logic [IW-1:0] fe_ftq_idx,
  output logic          fe_ready,
  output logic          fe_tgt_valid,
  output logic [AW-1:0] fe_tgt,
  input  logic          redir_valid,
  input  logic [IW-1:0] redir_ftq_idx,
  input  logic          redir_is_call,
  input  logic          redir_is_ret,
  input  logic [AW-1:0] redir_ret_addr,
  input  logic          commit_valid,
  input  logic [IW-1:0] commit_ftq_idx,
  output logic          ras_push,
  output logic [AW-1:0] ras_push_addr,
  output logic          ras_pop,
  input  logic [AW-1:0] ras_pop_addr,
  input  logic          ras_push_rdy,
  input  logic          ras_pop_rdy,
  input  logic [PW-1:0] ras_ptr,
  output logic          ras_recover,
  output logic [PW-1:0] ras_recover_ptr,
  output logic          ckpt_miss,
  output logic [7:0]    ovf_cnt
);

  import uarch_pkg::*;

  ras_ctrl_state_e state_q, state_d;
  redir_req_t      redir_q, redir_d;
  logic [AW-1:0]   swap_addr_q, swap_addr_d;
  logic [PW-1:0]   rec_ptr_q, rec_ptr_d;
  logic            ckpt_miss_q, ckpt_miss_d;
  logic [7:0]      ovf_q, ovf_d;
  logic            accept;
  logic [PW-1:0]   ckpt_rd_ptr;
  logic            ckpt_rd_vld;

  assign fe_ready     = (state_q == RC_IDLE) && !redir_valid;
  assign accept       = fe_valid && fe_ready;
  assign fe_tgt       = ras_pop_addr;
  assign fe_tgt_valid = fe_is_ret && ras_pop_rdy && (state_q == RC_IDLE);
  assign ckpt_miss    = ckpt_miss_q;
  assign ovf_cnt      = ovf_q;

  ras_ckpt_table #(
    .DEPTH (FTQ_DEPTH),
    .PW    (PW)
  ) u_ckpt (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_idx  (fe_ftq_idx),
    .wr_ptr  (ras_ptr),
    .clr_en  (commit_valid),
    .clr_idx (commit_ftq_idx),
    .rd_idx  (redir_ftq_idx),
    .rd_ptr  (ckpt_rd_ptr),
    .rd_vld  (ckpt_rd_vld)
  );

  // A redirect pre-empts whatever the FSM was doing and issues no command that cycle.
  always_comb begin
    state_d         = state_q;
    redir_d         = redir_q;
    swap_addr_d     = swap_addr_q;
    rec_ptr_d       = rec_ptr_q;
    ckpt_miss_d     = ckpt_miss_q;
    ovf_d           = ovf_q;
    ras_push        = 1'b0;
    ras_push_addr   = '0;
    ras_pop         = 1'b0;
    ras_recover     = 1'b0;
    ras_recover_ptr = '0;

    if (redir_valid) begin
      redir_d.is_call  = redir_is_call;
      redir_d.is_ret   = redir_is_ret;
      redir_d.ret_addr = redir_ret_addr;
      rec_ptr_d        = ckpt_rd_ptr;
      if (ckpt_rd_vld) begin
        state_d = RC_RECOVER;
      end else begin
        ckpt_miss_d = 1'b1;
        state_d     = RC_REPAIR;
      end
    end else begin
      unique case (state_q)
        RC_IDLE: begin
          if (accept) begin
            if (fe_is_call && fe_is_ret) begin
              ras_pop     = ras_pop_rdy;
              swap_addr_d = fe_ret_addr;
              state_d     = RC_SWAP;
            end else if (fe_is_call) begin
              if (ras_push_rdy) begin
                ras_push      = 1'b1;
                ras_push_addr = fe_ret_addr;
              end else begin
                ovf_d = sat_inc8(ovf_q);
              end
            end else if (fe_is_ret) begin
              ras_pop = ras_pop_rdy;
            end
          end
        end
        RC_SWAP: begin
          if (ras_push_rdy) begin
            ras_push      = 1'b1;
            ras_push_addr = swap_addr_q;
          end else begin
            ovf_d = sat_inc8(ovf_q);
          end
          state_d = RC_IDLE;
        end
        RC_RECOVER: begin
          ras_recover     = 1'b1;
          ras_recover_ptr = rec_ptr_q;
          state_d         = RC_REPAIR;
        end
        RC_REPAIR: begin
          state_d = RC_IDLE;
          if (redir_q.is_call && redir_q.is_ret) begin
            ras_pop     = ras_pop_rdy;
            swap_addr_d = redir_q.ret_addr;
            state_d     = RC_SWAP;
          end else if (redir_q.is_call) begin
            if (ras_push_rdy) begin
              ras_push      = 1'b1;
              ras_push_addr = redir_q.ret_addr;
            end else begin
              ovf_d = sat_inc8(ovf_q);
            end
          end else if (redir_q.is_ret) begin
            ras_pop = ras_pop_rdy;
          end
        end
        default: state_d = RC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RC_IDLE;
      redir_q     <= '0;
      swap_addr_q <= '0;
      rec_ptr_q   <= '0;
      ckpt_miss_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      redir_q     <= redir_d;
      swap_addr_q <= swap_addr_d;
      rec_ptr_q   <= rec_ptr_d;
      ckpt_miss_q <= ckpt_miss_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: a behavioural RAS plus a transaction-level model of
// the expected command stream, checked by an independent negedge monitor.
module tb_ras_ctrl;
  import uarch_pkg::*;

  localparam int unsigned AW    = CPU_ADDR_BITS;
  localparam int unsigned PW    = RAS_PW;
  localparam int unsigned IW    = FTQ_IW;
  localparam int unsigned DEPTH = RAS_DEPTH;

  logic          clk, rst_n;
  logic          fe_valid, fe_is_call, fe_is_ret, fe_ready, fe_tgt_valid;
  logic [AW-1:0] fe_ret_addr, fe_tgt;
  logic [IW-1:0] fe_ftq_idx, redir_ftq_idx, commit_ftq_idx;
  logic          redir_valid, redir_is_call, redir_is_ret, commit_valid;
  logic [AW-1:0] redir_ret_addr, ras_push_addr, ras_pop_addr;
  logic          ras_push, ras_pop, ras_push_rdy, ras_pop_rdy, ras_recover, ckpt_miss;
  logic [PW-1:0] ras_ptr, ras_recover_ptr;
  logic [7:0]    ovf_cnt;

  int checks = 0;
  int errors = 0;

  ras_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .fe_valid(fe_valid), .fe_is_call(fe_is_call), .fe_is_ret(fe_is_ret),
    .fe_ret_addr(fe_ret_addr), .fe_ftq_idx(fe_ftq_idx), .fe_ready(fe_ready),
    .fe_tgt_valid(fe_tgt_valid), .fe_tgt(fe_tgt),
    .redir_valid(redir_valid), .redir_ftq_idx(redir_ftq_idx),
    .redir_is_call(redir_is_call), .redir_is_ret(redir_is_ret),
    .redir_ret_addr(redir_ret_addr),
    .commit_valid(commit_valid), .commit_ftq_idx(commit_ftq_idx),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .ras_pop_addr(ras_pop_addr), .ras_push_rdy(ras_push_rdy), .ras_pop_rdy(ras_pop_rdy),
    .ras_ptr(ras_ptr), .ras_recover(ras_recover), .ras_recover_ptr(ras_recover_ptr),
    .ckpt_miss(ckpt_miss), .ovf_cnt(ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAS: pointer-addressed stack driven by the DUT's commands.
  logic [AW-1:0] r_mem [2**PW];
  logic [PW-1:0] r_ptr = '0;
  assign ras_ptr      = r_ptr;
  assign ras_push_rdy = r_ptr < PW'(DEPTH);
  assign ras_pop_rdy  = r_ptr != '0;
  assign ras_pop_addr = (r_ptr != '0) ? r_mem[r_ptr - PW'(1)] : '0;

  always @(posedge clk) begin
    if (ras_recover) r_ptr <= ras_recover_ptr;
    else if (ras_push) begin
      r_mem[r_ptr] <= ras_push_addr;
      r_ptr        <= r_ptr + PW'(1);
    end else if (ras_pop) r_ptr <= r_ptr - PW'(1);
  end

  // Reference model state
  typedef struct {
    bit            push;
    logic [AW-1:0] paddr;
    bit            pop;
    bit            rec;
    int            rptr;
    bit            tv;
    logic [AW-1:0] tgt;
  } ev_t;

  ev_t           exp_q[$];
  logic [AW-1:0] m_mem [2**PW];
  int            m_ptr = 0;
  int            m_ckpt [FTQ_DEPTH];
  bit            m_vld [FTQ_DEPTH];
  int            exp_ovf = 0;
  bit            exp_miss = 0;

  function automatic ev_t ev_clear();
    ev_t e;
    e.push = 0; e.paddr = '0; e.pop = 0; e.rec = 0; e.rptr = 0; e.tv = 0; e.tgt = '0;
    return e;
  endfunction

  function automatic void exp_cycle(input ev_t e);
    if (e.push || e.pop || e.rec || e.tv) exp_q.push_back(e);
  endfunction

  function automatic ev_t m_push(input logic [AW-1:0] a);
    ev_t e = ev_clear();
    if (m_ptr < int'(DEPTH)) begin
      e.push = 1; e.paddr = a;
      m_mem[m_ptr] = a;
      m_ptr++;
    end else if (exp_ovf < 255) exp_ovf++;
    return e;
  endfunction

  function automatic ev_t m_pop(input bit tgt_vis);
    ev_t e = ev_clear();
    if (m_ptr > 0) begin
      m_ptr--;
      e.pop = 1; e.tv = tgt_vis; e.tgt = m_mem[m_ptr];
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with any command or target activity consumes one expected record.
  ev_t mon_e;
  always @(negedge clk) begin
    if (rst_n && (ras_push || ras_pop || ras_recover || fe_tgt_valid)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected: got push=%0b pop=%0b rec=%0b tv=%0b at %0t",
                 ras_push, ras_pop, ras_recover, fe_tgt_valid, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.push != ras_push || mon_e.pop != ras_pop || mon_e.rec != ras_recover ||
            mon_e.tv != fe_tgt_valid || (mon_e.push && mon_e.paddr != ras_push_addr) ||
            (mon_e.rec && PW'(mon_e.rptr) != ras_recover_ptr) ||
            (mon_e.tv && mon_e.tgt != fe_tgt)) begin
          errors++;
          $display("FAIL cmd: got push=%0b/%h pop=%0b rec=%0b/%0d tv=%0b/%h want push=%0b/%h pop=%0b rec=%0b/%0d tv=%0b/%h at %0t",
                   ras_push, ras_push_addr, ras_pop, ras_recover, ras_recover_ptr, fe_tgt_valid, fe_tgt,
                   mon_e.push, mon_e.paddr, mon_e.pop, mon_e.rec, mon_e.rptr, mon_e.tv, mon_e.tgt, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    fe_valid = 0; fe_is_call = 0; fe_is_ret = 0; fe_ret_addr = '0; fe_ftq_idx = '0;
    redir_valid = 0; redir_is_call = 0; redir_is_ret = 0; redir_ret_addr = '0; redir_ftq_idx = '0;
    commit_valid = 0; commit_ftq_idx = '0;
  endtask

  task automatic wait_ready(input int lat, input string name);
    int n = 0;
    while (!fe_ready && n < 12) begin
      n++;
      tick();
    end
    check(name, 64'(n), 64'(lat));
  endtask

  task automatic fe_op(input int idx, input bit call, input bit ret, input logic [AW-1:0] addr,
                       input bit cm_en, input int cm_idx);
    int lat;
    bit tv_exp;
    lat    = (call && ret) ? 1 : 0;
    tv_exp = ret && (m_ptr > 0);
    if (cm_en) m_vld[cm_idx] = 0;
    m_ckpt[idx] = m_ptr;
    m_vld[idx]  = 1;
    if (call && ret) begin
      exp_cycle(m_pop(1'b1));
      exp_cycle(m_push(addr));
    end else if (call) exp_cycle(m_push(addr));
    else if (ret) exp_cycle(m_pop(1'b1));
    fe_valid = 1; fe_is_call = call; fe_is_ret = ret; fe_ret_addr = addr; fe_ftq_idx = IW'(idx);
    commit_valid = cm_en; commit_ftq_idx = IW'(cm_idx);
    #1;
    check("fe_tgt_valid", 64'(fe_tgt_valid), 64'(tv_exp));
    tick();
    clear_inputs();
    wait_ready(lat, "fe_lat");
  endtask

  task automatic redir_model(input int idx, input bit call, input bit ret, input logic [AW-1:0] addr,
                             input bit cm_en, input int cm_idx, output int lat);
    ev_t e = ev_clear();
    if (m_vld[idx]) begin
      e.rec = 1; e.rptr = m_ckpt[idx];
      exp_cycle(e);
      m_ptr = m_ckpt[idx];
      lat = 2;
    end else begin
      exp_miss = 1;
      lat = 1;
    end
    if (cm_en) m_vld[cm_idx] = 0;
    if (call && ret) begin
      exp_cycle(m_pop(1'b0));
      exp_cycle(m_push(addr));
      lat++;
    end else if (call) exp_cycle(m_push(addr));
    else if (ret) exp_cycle(m_pop(1'b0));
  endtask

  task automatic drive_redir(input int idx, input bit call, input bit ret, input logic [AW-1:0] addr,
                             input bit cm_en, input int cm_idx);
    redir_valid = 1; redir_ftq_idx = IW'(idx); redir_is_call = call; redir_is_ret = ret;
    redir_ret_addr = addr; commit_valid = cm_en; commit_ftq_idx = IW'(cm_idx);
    tick();
    clear_inputs();
  endtask

  task automatic redirect(input int idx, input bit call, input bit ret, input logic [AW-1:0] addr,
                          input bit cm_en, input int cm_idx);
    int lat;
    redir_model(idx, call, ret, addr, cm_en, cm_idx, lat);
    drive_redir(idx, call, ret, addr, cm_en, cm_idx);
    wait_ready(lat, "redir_lat");
  endtask

  task automatic commit_only(input int idx);
    m_vld[idx] = 0;
    commit_valid = 1; commit_ftq_idx = IW'(idx);
    tick();
    clear_inputs();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_push"}, 64'(ras_push), 0);
    check({tag, "_pop"}, 64'(ras_pop), 0);
    check({tag, "_recover"}, 64'(ras_recover), 0);
    check({tag, "_recover_ptr"}, 64'(ras_recover_ptr), 0);
    check({tag, "_fe_ready"}, 64'(fe_ready), 1);
    check({tag, "_ckpt_miss"}, 64'(ckpt_miss), 64'(exp_miss));
    check({tag, "_ovf"}, 64'(ovf_cnt), 64'(exp_ovf));
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 2**PW; i++) begin
      r_mem[i] = '0;
      m_mem[i] = '0;
    end
    for (int i = 0; i < int'(FTQ_DEPTH); i++) begin
      m_vld[i] = 0;
      m_ckpt[i] = 0;
    end
    clear_inputs();
    rst_n = 0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1;
    tick();

    // Call then return: push, then predicted target equals the pushed link address.
    fe_op(0, 1, 0, 32'h1000, 0, 0);
    fe_op(1, 0, 1, '0, 0, 0);

    // Calls at slots 0..3 then a plain redirect to slot 2.
    for (int i = 0; i < 4; i++) fe_op(i, 1, 0, AW'(32'h100 + 4 * i), 0, 0);
    redirect(2, 0, 0, '0, 0, 0);

    // Redirect as a call: restore to 1, then push the link address.
    redirect(1, 1, 0, 32'h2000, 0, 0);
    check("t3_ras_ptr", 64'(ras_ptr), 2);

    // Coroutine block swaps the top of stack.
    fe_op(4, 1, 0, 32'hA000, 0, 0);
    fe_op(5, 1, 1, 32'hB000, 0, 0);

    // Overflow and empty-stack return.
    redirect(0, 0, 0, '0, 0, 0);
    for (int i = 0; i < 17; i++) fe_op(i % 16, 1, 0, $urandom(), 0, 0);
    check("ovf_one", 64'(ovf_cnt), 1);
    for (int i = 0; i < 16; i++) fe_op(i % 16, 0, 1, '0, 0, 0);
    fe_op(8, 0, 1, '0, 0, 0);

    // Committed slot has no checkpoint.
    commit_only(3);
    redirect(3, 0, 0, '0, 0, 0);
    check("ckpt_miss_set", 64'(ckpt_miss), 1);

    // Second redirect while recovering restarts with its own pointer.
    fe_op(6, 1, 0, 32'h6000, 0, 0);
    fe_op(7, 1, 0, 32'h7000, 0, 0);
    fe_op(10, 1, 0, 32'h7400, 0, 0);
    redir_model(7, 0, 0, '0, 0, 0, lat);
    drive_redir(6, 0, 0, '0, 0, 0);
    drive_redir(7, 0, 0, '0, 0, 0);
    wait_ready(lat, "override_lat");

    // Reset in REPAIR: the pending replay push must not appear.
    fe_op(9, 0, 0, '0, 0, 0);
    begin
      ev_t e = ev_clear();
      e.rec = 1; e.rptr = m_ckpt[9];
      exp_cycle(e);
      m_ptr = m_ckpt[9];
    end
    drive_redir(9, 1, 0, 32'hC000, 0, 0);
    tick();
    rst_n = 0;
    #1;
    exp_miss = 0;
    exp_ovf = 0;
    for (int i = 0; i < int'(FTQ_DEPTH); i++) m_vld[i] = 0;
    check_idle_outputs("mid_reset");
    tick();
    rst_n = 1;
    tick();
    redirect(5, 0, 1, '0, 0, 0);
    check("miss_after_reset", 64'(ckpt_miss), 1);

    // Saturating overflow counter.
    for (int i = 0; i < 300; i++) fe_op(i % 16, 1, 0, $urandom(), 0, 0);
    check("ovf_sat", 64'(ovf_cnt), 255);

    // Random mix of fetch ops, redirects and commits.
    for (int n = 0; n < 400; n++) begin
      int      kind;
      int      idx;
      int      cidx;
      bit      cm;
      bit      c;
      bit      r;
      kind = int'($urandom_range(0, 9));
      idx  = int'($urandom_range(0, FTQ_DEPTH - 1));
      cidx = ($urandom_range(0, 3) == 0) ? idx : int'($urandom_range(0, FTQ_DEPTH - 1));
      cm   = $urandom_range(0, 3) == 0;
      c    = $urandom_range(0, 1) == 1;
      r    = $urandom_range(0, 1) == 1;
      if (kind <= 5) fe_op(idx, c, r, $urandom(), cm, cidx);
      else if (kind <= 7) redirect(idx, c, r, $urandom(), cm, cidx);
      else if (kind == 8) commit_only(idx);
      else tick();
    end

    repeat (4) tick();
    check("exp_q_drained", 64'(exp_q.size()), 0);
    check("final_ovf", 64'(ovf_cnt), 64'(exp_ovf));
    check("final_miss", 64'(ckpt_miss), 64'(exp_miss));
    check("final_ras_ptr", 64'(ras_ptr), 64'(m_ptr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Sequencing controller for the return address stack, between the fetch-stage predecoder, backend redirect logic and the `ras` instance. Turns per-fetch-block call/return hints into RAS push/pop commands and supplies predicted return targets. Keeps one RAS-pointer checkpoint per FTQ entry. On a backend redirect it restores the RAS pointer, then replays the redirecting instruction's own call/return effect.

## Interface
- `RAS_DEPTH`, default 16: depth of the attached RAS. `PW = $clog2(RAS_DEPTH)+1`.
- `FTQ_DEPTH`, default 16: number of checkpoint slots. `IW = $clog2(FTQ_DEPTH)`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fe_valid` in 1: fetch block carries a RAS-relevant op.
- `fe_is_call` in 1: block contains a call.
- `fe_is_ret` in 1: block contains a return.
- `fe_ret_addr` in CPU_ADDR_BITS: link address to push for a call.
- `fe_ftq_idx` in IW: FTQ slot of the block.
- `fe_ready` out 1: op accepted this cycle when high with `fe_valid`.
- `fe_tgt_valid` out 1: `fe_tgt` is a usable return prediction.
- `fe_tgt` out CPU_ADDR_BITS: predicted return target.
- `redir_valid` in 1: backend redirect.
- `redir_ftq_idx` in IW: FTQ slot of the redirecting block.
- `redir_is_call` in 1: the redirecting instruction is a call.
- `redir_is_ret` in 1: the redirecting instruction is a return.
- `redir_ret_addr` in CPU_ADDR_BITS: link address for a replayed call.
- `commit_valid` in 1: frees one checkpoint.
- `commit_ftq_idx` in IW: slot to free.
- `ras_push` out 1, `ras_push_addr` out CPU_ADDR_BITS, `ras_pop` out 1: RAS commands.
- `ras_pop_addr` in CPU_ADDR_BITS: RAS top of stack.
- `ras_push_rdy` in 1, `ras_pop_rdy` in 1: RAS not full / not empty.
- `ras_ptr` in PW: current RAS pointer.
- `ras_recover` out 1, `ras_recover_ptr` out PW: RAS restore command.
- `ckpt_miss` out 1: sticky; a redirect hit an invalid checkpoint.
- `ovf_cnt` out 8: saturating count of dropped pushes.

## Operation
- States: IDLE, SWAP, RECOVER, REPAIR.
- `fe_ready = (state==IDLE) && !redir_valid`.
- Accept means `fe_valid && fe_ready`. On accept:
  - `ckpt[fe_ftq_idx] <= ras_ptr`, captured before this block's op.
  - `vld[fe_ftq_idx] <= 1`.
- Return target:
  - `fe_tgt = ras_pop_addr`, combinational.
  - `fe_tgt_valid = fe_is_ret && ras_pop_rdy && state==IDLE`.
- Call only: `ras_push` with `fe_ret_addr` if `ras_push_rdy`. Otherwise drop it and increment `ovf_cnt`, saturating at 255.
- Return only: `ras_pop` if `ras_pop_rdy`. Otherwise no pop and `fe_tgt_valid=0`.
- Call and return in one block (coroutine):
  - Cycle 0: pop if `ras_pop_rdy`, latch `fe_ret_addr`, go to SWAP.
  - SWAP: push the latched address under the same overflow rule, then IDLE.
- Redirect from any state; it overrides SWAP and an in-progress recovery.
  - Latch the redirect fields.
  - Checkpoint valid: go to RECOVER.
  - Checkpoint invalid: set `ckpt_miss`, no recover, go to REPAIR.
- RECOVER (1 cycle): `ras_recover=1`, `ras_recover_ptr=ckpt[idx]`, then REPAIR.
- REPAIR (1 cycle):
  - Latched call: push `redir_ret_addr`.
  - Latched return: pop.
  - Both: pop this cycle, then SWAP pushes.
  - Neither: no op.
  - Then IDLE, or SWAP when both.
- Commit: `vld[commit_ftq_idx] <= 0`. A same-cycle redirect reads the slot before the clear.
- Accept and commit to the same slot in one cycle: the accept wins.
- At most one of `ras_push`, `ras_pop`, `ras_recover` is high in any cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - State IDLE, all `vld=0`, `ckpt_miss=0`, `ovf_cnt=0`.
  - All command outputs 0; `ras_recover_ptr=0`.
- `fe_tgt` has 0-cycle latency. RAS commands are issued in the accept cycle and take effect at the next edge.
- Redirect to IDLE takes 2 cycles (RECOVER, REPAIR), or 3 cycles when the instruction is both call and return.
- `fe_ready` is low during SWAP, RECOVER and REPAIR, and in any cycle with `redir_valid`.
- `ras_push_rdy` / `ras_pop_rdy` are sampled in the cycle the command is driven.
- Reset asserted mid-recovery: state returns to IDLE immediately with outputs deasserted.

## Structure
- `uarch_pkg` additions: `RAS_DEPTH`, `FTQ_DEPTH`, `ras_ptr_t` (PW bits), `ras_ctrl_state_e`.
- Sub-module `ras_ckpt_table`:
  - FTQ_DEPTH x PW pointers plus valid bits.
  - One write port (accept), one clear port (commit), one combinational read port (redirect).
- The `ras` itself is instantiated by the parent, not inside this block.

## Test plan
1. Call `0x1000` accepted at idx 0, then return at idx 1 -> push in cycle 0; `fe_tgt=0x1000` with `fe_tgt_valid=1`; pop issued; `ckpt[1]=1`.
2. Calls at idx 0–3 (`ckpt` 0,1,2,3), then redirect idx 2 as a non-call -> `ras_recover_ptr=2` next cycle, no REPAIR op, `fe_ready` returns high after 2 cycles.
3. Redirect idx 1 with `redir_is_call`, `redir_ret_addr=0x2000` -> recover to 1, then push `0x2000`; `ras_ptr` becomes 2.
4. Coroutine block with RAS holding `0xA000`, `fe_ret_addr=0xB000` -> `fe_tgt=0xA000`; pop, then push `0xB000` the next cycle; `fe_ready` is low for 1 cycle.
5. 17 calls with RAS_DEPTH=16 -> 16 pushes issued, the 17th dropped, `ovf_cnt=1`. Return with an empty RAS -> `fe_tgt_valid=0`, no pop.
6. Commit idx 3, then redirect idx 3 -> `ckpt_miss=1`, no `ras_recover`. Redirect arriving during RECOVER -> restarts with the new pointer. `rst_n` low mid-REPAIR -> IDLE and all commands 0.
